// File: rtl/ball_movement.sv
// Pong ball position and direction tracker: reflects on collision edges,
// steps on move ticks, clamps at the y limits and reports a miss past either x edge.
module ball_movement #(
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned X_START = 320,
  parameter int unsigned Y_START = 240,
  parameter int unsigned STEP    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           paddle_collision,
  input  logic           wall_collision,
  input  logic           counter,
  output logic           bx_dir,
  output logic           by_dir,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           miss
);

  localparam logic signed [X_W:0] XStep = (X_W+1)'(STEP);
  localparam logic signed [Y_W:0] YStep = (Y_W+1)'(STEP);
  localparam logic signed [X_W:0] XMaxS = (X_W+1)'(X_MAX);
  localparam logic signed [Y_W:0] YMaxS = (Y_W+1)'(Y_MAX);

  logic paddle_q, wall_q;
  logic paddle_ev, wall_ev;
  logic bx_eff, by_eff;
  logic bx_d, by_d, miss_d;
  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  logic signed [X_W:0] x_calc;
  logic signed [Y_W:0] y_calc;

  assign paddle_ev = paddle_collision & ~paddle_q;
  assign wall_ev   = wall_collision & ~wall_q;
  // Movement uses the direction after this cycle's collision events.
  assign bx_eff    = bx_dir ^ paddle_ev;
  assign by_eff    = by_dir ^ wall_ev;

  always_comb begin
    bx_d   = bx_eff;
    by_d   = by_eff;
    x_d    = x_o;
    y_d    = y_o;
    miss_d = 1'b0;
    x_calc = bx_eff ? ($signed({1'b0, x_o}) + XStep) : ($signed({1'b0, x_o}) - XStep);
    y_calc = by_eff ? ($signed({1'b0, y_o}) + YStep) : ($signed({1'b0, y_o}) - YStep);
    if (counter) begin
      if (x_calc < 0 || x_calc > XMaxS) begin
        // Respawn at centre and serve toward the opposite side.
        miss_d = 1'b1;
        x_d    = X_W'(X_START);
        y_d    = Y_W'(Y_START);
        bx_d   = ~bx_eff;
      end else begin
        x_d = x_calc[X_W-1:0];
        if (y_calc < 0) begin
          y_d  = '0;
          by_d = 1'b1;
        end else if (y_calc > YMaxS) begin
          y_d  = Y_W'(Y_MAX);
          by_d = 1'b0;
        end else begin
          y_d = y_calc[Y_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      paddle_q <= 1'b0;
      wall_q   <= 1'b0;
      bx_dir   <= 1'b1;
      by_dir   <= 1'b1;
      x_o      <= X_W'(X_START);
      y_o      <= Y_W'(Y_START);
      miss     <= 1'b0;
    end else begin
      paddle_q <= paddle_collision;
      wall_q   <= wall_collision;
      bx_dir   <= bx_d;
      by_dir   <= by_d;
      x_o      <= x_d;
      y_o      <= y_d;
      miss     <= miss_d;
    end
  end

endmodule

// File: tb/tb_ball_movement.sv
// Directed self-checking bench for ball_movement: vector table plus clamp, miss,
// tie-break and asynchronous reset sequences.
module tb_ball_movement;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       paddle_collision = 1'b0;
  logic       wall_collision = 1'b0;
  logic       counter = 1'b0;
  logic       bx_dir, by_dir, miss;
  logic [9:0] x_o, y_o;

  int tests = 0;
  int fails = 0;

  ball_movement dut (
    .clk              (clk),
    .reset            (reset),
    .paddle_collision (paddle_collision),
    .wall_collision   (wall_collision),
    .counter          (counter),
    .bx_dir           (bx_dir),
    .by_dir           (by_dir),
    .x_o              (x_o),
    .y_o              (y_o),
    .miss             (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic p, w, c;
    logic bx, by;
    int   x, y;
    logic m;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic bx, input logic by, input int x,
                         input int y, input logic m);
    chk({name, " bx_dir"}, int'(bx_dir), int'(bx));
    chk({name, " by_dir"}, int'(by_dir), int'(by));
    chk({name, " x_o"}, int'(x_o), x);
    chk({name, " y_o"}, int'(y_o), y);
    chk({name, " miss"}, int'(miss), int'(m));
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           p     w     c     bx    by    x    y    miss
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 320, 240, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 320, 240, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 320, 240, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 320, 240, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 320, 240, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 320, 240, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 319, 241, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 318, 240, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 318, 240, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 318, 240, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 318, 240, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 319, 241, 1'b0};

    #10 reset = 1'b1;
    #1;
    chk_all("reset", 1'b1, 1'b1, 320, 240, 1'b0);

    for (int i = 0; i < 12; i++) begin
      paddle_collision = vecs[i].p;
      wall_collision   = vecs[i].w;
      counter          = vecs[i].c;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].bx, vecs[i].by, vecs[i].x, vecs[i].y, vecs[i].m);
    end
    paddle_collision = 1'b0;
    wall_collision   = 1'b0;

    // Ride down to y=478, then hit the bottom limit.
    counter = 1'b1;
    for (int i = 0; i < 237; i++) step();
    chk_all("ride_down", 1'b1, 1'b1, 556, 478, 1'b0);
    step();
    chk_all("y_reach_max", 1'b1, 1'b1, 557, 479, 1'b0);
    step();
    chk_all("y_clamp", 1'b1, 1'b0, 558, 479, 1'b0);
    step();
    chk_all("y_after_clamp", 1'b1, 1'b0, 559, 478, 1'b0);
    counter = 1'b0;

    // Fresh start, head left until x=0.
    reset = 1'b0;
    #2 reset = 1'b1;
    paddle_collision = 1'b1;
    step();
    paddle_collision = 1'b0;
    chk_all("flip_left", 1'b0, 1'b1, 320, 240, 1'b0);
    counter = 1'b1;
    for (int i = 0; i < 320; i++) step();
    chk_all("at_left_edge", 1'b0, 1'b0, 0, 399, 1'b0);

    // Paddle event in the crossing cycle turns the ball back: no miss.
    paddle_collision = 1'b1;
    step();
    chk_all("tie_break", 1'b1, 1'b0, 1, 398, 1'b0);
    counter = 1'b0;
    paddle_collision = 1'b0;
    step();
    paddle_collision = 1'b1;
    step();
    paddle_collision = 1'b0;
    chk_all("flip_again", 1'b0, 1'b0, 1, 398, 1'b0);
    counter = 1'b1;
    step();
    chk_all("back_to_zero", 1'b0, 1'b0, 0, 397, 1'b0);
    step();
    chk_all("miss", 1'b1, 1'b0, 320, 240, 1'b1);
    counter = 1'b0;
    step();
    chk_all("miss_clear", 1'b1, 1'b0, 320, 240, 1'b0);

    counter = 1'b1;
    step();
    chk_all("serve_right", 1'b1, 1'b0, 321, 239, 1'b0);
    // Reset lands mid-cycle while a tick is pending.
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", 1'b1, 1'b1, 320, 240, 1'b0);
    step();
    chk_all("reset_held", 1'b1, 1'b1, 320, 240, 1'b0);
    counter = 1'b0;
    #2 reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
